lcd_ctrl: RTL and testbench

Downstream consumer of the processor's 32-bit LCD output register (the `io_lcd` word), which drives an HD44780-compatible character LCD. Software writes command or data bytes into the register and toggles the enable bit. This block turns each request into a correctly timed bus write: setup, enable pulse, hold, then the controller's execution wait. It holds one pending request while busy and reports busy and overflow back for a status register.

---
 rtl/lcd_ctrl_if.sv | 22 ++
 rtl/lcd_ctrl.sv | 152 +++++++++++++++
 tb/tb_lcd_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_if.sv
// Bundle between the processor's io_lcd register and the LCD write controller.
// The master drives the register word; the slave drives the LCD pins and status.
interface lcd_ctrl_if;
   logic [31:0] lcd_word_i;
   logic        lcd_on_o;
   logic        lcd_rs_o;
   logic        lcd_rw_o;
   logic        lcd_en_o;
   logic [7:0]  lcd_data_o;
   logic        busy_o;
   logic        overflow_o;

   modport master (
      output lcd_word_i,
      input  lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o, busy_o, overflow_o
   );

   modport slave (
      input  lcd_word_i,
      output lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o, busy_o, overflow_o
   );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: turns rising edges of the EN request bit into timed
// setup/pulse/hold/wait bus cycles, with a one-entry pending buffer.
module lcd_ctrl #(
   parameter int unsigned SETUP_CYC      = 3,
   parameter int unsigned PULSE_CYC      = 12,
   parameter int unsigned HOLD_CYC       = 2,
   parameter int unsigned SHORT_WAIT_CYC = 2000,
   parameter int unsigned LONG_WAIT_CYC  = 80000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   lcd_ctrl_if.slave  bus
);

   localparam int unsigned Max01  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int unsigned Max012 = (Max01 > HOLD_CYC) ? Max01 : HOLD_CYC;
   localparam int unsigned MaxW   = (SHORT_WAIT_CYC > LONG_WAIT_CYC) ? SHORT_WAIT_CYC
                                                                     : LONG_WAIT_CYC;
   localparam int unsigned MaxCyc = (Max012 > MaxW) ? Max012 : MaxW;
   localparam int unsigned CntW   = $clog2(MaxCyc + 1);

   typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StWait} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              en_prev_q;
   logic              on_q;
   logic              rs_q, rs_d;
   logic [7:0]        data_q, data_d;
   logic              pend_q, pend_d;
   logic              pend_rs_q, pend_rs_d;
   logic [7:0]        pend_data_q, pend_data_d;
   logic              ovf_q, ovf_d;

   logic              req;
   logic              is_long;
   logic              cnt_last;
   logic              wait_done;
   logic              unused_bits;

   assign req         = bus.lcd_word_i[10] & ~en_prev_q;
   assign is_long     = ~rs_q & (data_q[7:2] == 6'd0) & (data_q[1:0] != 2'd0);
   assign cnt_last    = (cnt_q == CntW'(1));
   assign wait_done   = (state_q == StWait) & cnt_last;
   assign unused_bits = ^{bus.lcd_word_i[30:11], bus.lcd_word_i[8]};

   always_comb begin
      state_d     = state_q;
      cnt_d       = (state_q == StIdle) ? cnt_q : cnt_q - CntW'(1);
      rs_d        = rs_q;
      data_d      = data_q;
      pend_d      = pend_q;
      pend_rs_d   = pend_rs_q;
      pend_data_d = pend_data_q;
      ovf_d       = ovf_q;

      case (state_q)
         StIdle: begin
            if (req) begin
               state_d = StSetup;
               cnt_d   = CntW'(SETUP_CYC);
               rs_d    = bus.lcd_word_i[9];
               data_d  = bus.lcd_word_i[7:0];
            end
         end
         StSetup: begin
            if (cnt_last) begin
               state_d = StPulse;
               cnt_d   = CntW'(PULSE_CYC);
            end
         end
         StPulse: begin
            if (cnt_last) begin
               state_d = StHold;
               cnt_d   = CntW'(HOLD_CYC);
            end
         end
         StHold: begin
            if (cnt_last) begin
               state_d = StWait;
               cnt_d   = is_long ? CntW'(LONG_WAIT_CYC) : CntW'(SHORT_WAIT_CYC);
            end
         end
         StWait: begin
            if (cnt_last) begin
               if (pend_q) begin
                  state_d = StSetup;
                  cnt_d   = CntW'(SETUP_CYC);
                  rs_d    = pend_rs_q;
                  data_d  = pend_data_q;
                  pend_d  = 1'b0;
               end else if (req) begin
                  state_d = StSetup;
                  cnt_d   = CntW'(SETUP_CYC);
                  rs_d    = bus.lcd_word_i[9];
                  data_d  = bus.lcd_word_i[7:0];
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // A request while busy fills the slot; the slot frees up on the same edge
      // the pending entry is launched, so that case is not an overflow.
      if (req && (state_q != StIdle) && !(wait_done && !pend_q)) begin
         if (pend_q && !wait_done) begin
            ovf_d = 1'b1;
         end else begin
            pend_d      = 1'b1;
            pend_rs_d   = bus.lcd_word_i[9];
            pend_data_d = bus.lcd_word_i[7:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         en_prev_q   <= 1'b0;
         on_q        <= 1'b0;
         rs_q        <= 1'b0;
         data_q      <= 8'h00;
         pend_q      <= 1'b0;
         pend_rs_q   <= 1'b0;
         pend_data_q <= 8'h00;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         en_prev_q   <= bus.lcd_word_i[10];
         on_q        <= bus.lcd_word_i[31];
         rs_q        <= rs_d;
         data_q      <= data_d;
         pend_q      <= pend_d;
         pend_rs_q   <= pend_rs_d;
         pend_data_q <= pend_data_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.lcd_on_o   = on_q;
   assign bus.lcd_rs_o   = rs_q;
   assign bus.lcd_rw_o   = 1'b0;
   assign bus.lcd_en_o   = (state_q == StPulse);
   assign bus.lcd_data_o = data_q;
   assign bus.busy_o     = (state_q != StIdle) | pend_q;
   assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: directed scenarios plus random traffic,
// compared each cycle against a transaction-timeline reference model.
module tb_lcd_ctrl;
   localparam int unsigned S  = 2;
   localparam int unsigned P  = 4;
   localparam int unsigned H  = 1;
   localparam int unsigned SW = 10;
   localparam int unsigned LW = 50;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lcd_ctrl_if bus ();

   lcd_ctrl #(
      .SETUP_CYC      (S),
      .PULSE_CYC      (P),
      .HOLD_CYC       (H),
      .SHORT_WAIT_CYC (SW),
      .LONG_WAIT_CYC  (LW)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: a transaction occupies [t0, t0+len) edges; the E pulse is
   // a fixed window inside it. Pending is a single slot.
   int         m_cyc = 0;
   int         m_t0  = 0;
   int         m_len = 0;
   bit         m_act, m_pv, m_ovf, m_prev, m_on, m_rs, m_prs;
   logic [7:0] m_data, m_pdata;

   function automatic int tlen(input bit rs, input logic [7:0] d);
      bit lng = !rs && (d[7:2] == 6'd0) && (d[1:0] != 2'd0);
      return S + P + H + (lng ? LW : SW);
   endfunction

   task automatic model_reset();
      m_act = 0; m_pv = 0; m_ovf = 0; m_prev = 0; m_on = 0;
      m_rs = 0; m_data = 8'h00; m_prs = 0; m_pdata = 8'h00;
   endtask

   task automatic model_start(input bit rs, input logic [7:0] d);
      m_act = 1; m_t0 = m_cyc; m_rs = rs; m_data = d; m_len = tlen(rs, d);
   endtask

   task automatic model_step(input logic [31:0] w);
      bit req;
      m_cyc++;
      req    = w[10] && !m_prev;
      m_prev = w[10];
      m_on   = w[31];
      if (m_act && m_cyc == m_t0 + m_len) begin
         if (m_pv) begin
            model_start(m_prs, m_pdata);
            m_pv = 0;
            if (req) begin m_pv = 1; m_prs = w[9]; m_pdata = w[7:0]; end
         end else if (req) model_start(w[9], w[7:0]);
         else m_act = 0;
      end else if (m_act) begin
         if (req) begin
            if (m_pv) m_ovf = 1;
            else begin m_pv = 1; m_prs = w[9]; m_pdata = w[7:0]; end
         end
      end else if (req) model_start(w[9], w[7:0]);
   endtask

   task automatic compare_all();
      int ph = m_cyc - m_t0;
      check("lcd_on", bus.lcd_on_o, m_on);
      check("lcd_rs", bus.lcd_rs_o, m_rs);
      check("lcd_rw", bus.lcd_rw_o, 1'b0);
      check("lcd_data", bus.lcd_data_o, m_data);
      check("lcd_en", bus.lcd_en_o, m_act && ph >= int'(S) && ph < int'(S + P));
      check("busy", bus.busy_o, m_act || m_pv);
      check("overflow", bus.overflow_o, m_ovf);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(bus.lcd_word_i);
      @(negedge clk);
      compare_all();
   endtask

   task automatic reset_dut(input int n);
      rst_n = 1'b0;
      model_reset();
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         compare_all();
      end
      rst_n = 1'b1;
   endtask

   task automatic set_word(input bit on, input bit en, input bit rs, input logic [7:0] d);
      bus.lcd_word_i = {on, 20'h0, en, rs, 1'b0, d};
   endtask

   // Runs until busy drops (bounded); checks duration and number of E pulses.
   task automatic measure(input string tag, input int exp_len, input int exp_pulses);
      int n = 0;
      int pulses = 0;
      logic prev_en = bus.lcd_en_o;
      while (bus.busy_o && n < 200) begin
         cycle();
         n++;
         if (bus.lcd_en_o && !prev_en) pulses++;
         prev_en = bus.lcd_en_o;
      end
      check({tag, "_len"}, n, exp_len);
      check({tag, "_pulses"}, pulses, exp_pulses);
   endtask

   logic [7:0] seen[$];
   logic       prev_e;
   logic [31:0] r;

   initial begin
      model_reset();
      bus.lcd_word_i = 32'h8000_0000;
      @(negedge clk);
      reset_dut(3);
      cycle();
      check("on_after_rst", bus.lcd_on_o, 1'b1);
      check("idle_busy", bus.busy_o, 1'b0);

      // Data write, request level held high: one pulse, busy for 17 cycles.
      set_word(1, 1, 1, 8'h41);
      cycle();
      check("cap_data", bus.lcd_data_o, 8'h41);
      measure("short", S + P + H + SW, 1);
      set_word(1, 0, 0, 8'h00);
      cycle();

      set_word(1, 1, 0, 8'h01);
      cycle();
      measure("long", S + P + H + LW, 1);
      set_word(1, 0, 0, 8'h00);
      cycle();
      set_word(1, 1, 0, 8'h04);
      cycle();
      measure("not_long", S + P + H + SW, 1);
      set_word(1, 0, 0, 8'h00);
      cycle();

      // Three requests while busy: third one dropped.
      seen.delete();
      prev_e = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_word(1, 1, 1, 8'h41 + 8'(i));
         cycle();
         set_word(1, 0, 1, 8'h00);
         cycle();
      end
      check("ovf_set", bus.overflow_o, 1'b1);
      for (int n = 0; n < 100 && bus.busy_o; n++) begin
         if (bus.lcd_en_o && !prev_e) seen.push_back(bus.lcd_data_o);
         prev_e = bus.lcd_en_o;
         cycle();
      end
      check("b2b_count", seen.size(), 2);
      if (seen.size() == 2) begin
         check("b2b_first", seen[0], 8'h41);
         check("b2b_second", seen[1], 8'h42);
      end
      check("ovf_sticky", bus.overflow_o, 1'b1);
      reset_dut(2);
      check("ovf_cleared", bus.overflow_o, 1'b0);

      // Request lands exactly on the WAIT expiry edge with no pending entry.
      set_word(1, 1, 1, 8'h41);
      cycle();
      set_word(1, 0, 1, 8'h41);
      repeat (S + P + H + SW - 1) cycle();
      set_word(1, 1, 0, 8'h55);
      cycle();
      check("direct_data", bus.lcd_data_o, 8'h55);
      check("direct_busy", bus.busy_o, 1'b1);
      check("direct_ovf", bus.overflow_o, 1'b0);
      set_word(1, 0, 0, 8'h55);
      for (int n = 0; n < 100 && bus.busy_o; n++) cycle();

      // Asynchronous reset with E high and a request pending.
      set_word(1, 1, 1, 8'h41);
      cycle();
      set_word(1, 0, 1, 8'h41);
      cycle();
      set_word(1, 1, 1, 8'h42);
      cycle();
      check("pre_rst_en", bus.lcd_en_o, 1'b1);
      #2;
      set_word(1, 0, 1, 8'h42);
      rst_n = 1'b0;
      #1;
      check("async_en", bus.lcd_en_o, 1'b0);
      check("async_busy", bus.busy_o, 1'b0);
      @(negedge clk);
      reset_dut(2);
      repeat (20) cycle();
      set_word(1, 1, 1, 8'h46);
      cycle();
      measure("after_rst", S + P + H + SW, 1);

      // Random traffic, with occasional resets to clear the sticky flag.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) reset_dut(1);
         r = $urandom;
         if ($urandom_range(0, 5) == 0) r[10] = ~bus.lcd_word_i[10];
         else r[10] = bus.lcd_word_i[10];
         if ($urandom_range(0, 2) == 0) r[7:0] = 8'($urandom_range(0, 4));
         if ($urandom_range(0, 1) == 0) r[9] = 1'b0;
         bus.lcd_word_i = r;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
